// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM encoding for the binary-to-BCD converter
// Used by bin2bcd_seq and bcd_add3.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  // Digit count of the downstream seven-segment driver.
  localparam int SEG_DIGITS = 3;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit adjust, digit >= 5 ? digit + 3 : digit
// Ports: digit (in, 4b), adj (out, 4b).
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  assign adj = (digit >= ADD3_THRESH) ?
               digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per clock.
// Ports: clk, rst (sync, high), start, bin -> busy, done, bcd,
// blank_mask (only when BIN2BCD_LZB_EN is defined).
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = SEG_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
`ifdef BIN2BCD_LZB_EN
  output logic [DIGITS-1:0]             blank_mask,
`endif
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   nxt_scratch;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]   cnt;
  logic            last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjust first, then shift {scratch, sh} left by one.
  assign nxt_scratch = BW'({adj, sh[WIDTH-1]});
  assign last        = (cnt == CW'(WIDTH - 1));

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] mask_nxt;
  logic              hi_zero;

  // Blank a digit only if it and every higher digit are zero;
  // the units digit is always shown.
  always_comb begin
    mask_nxt = '0;
    hi_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero = hi_zero &
        (nxt_scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      mask_nxt[k] = hi_zero;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      scratch <= '0;
      sh      <= '0;
      cnt     <= '0;
`ifdef BIN2BCD_LZB_EN
      blank_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sh      <= bin;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          scratch <= nxt_scratch;
          sh      <= sh << 1;
          cnt     <= cnt + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= nxt_scratch;
`ifdef BIN2BCD_LZB_EN
            blank_mask <= mask_nxt;
`endif
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
